gps_cfg_scheduler: RTL and testbench
====================================

GPS_CFG_SCHEDULER -- requirements
Module: gps_cfg_scheduler

Interface
REQ-001 SHALL have parameter MAX_SAT, default 32: highest satellite ID visited in scan mode.
REQ-002 SHALL have ports clk_in, input, 1: single clock; rst_in, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have ports enable_in, input, 1; n_sat_in, input, 5; ca_phase_start_in, input, 1; ca_phase_in, input, 16; doppler_in, input, 8; snr_in, input, 8; noise_off_in, input, 1; signal_off_in, input, 1. These carry live register-bank values.
REQ-004 SHALL have ports code_phase_done_in, input, 1: one-cycle pulse at the generator C/A epoch (1 ms).
REQ-005 SHALL have ports scan_ena_in, input, 1: auto satellite scan; dwell_in, input, 8: epochs per satellite minus 1.
REQ-006 SHALL have ports gen_enable_out, output, 1; n_sat_out, output, 5; ca_phase_load_out, output, 1 (one-cycle pulse); ca_phase_out, output, 16; doppler_out, output, 8; snr_out, output, 8; noise_off_out, output, 1; signal_off_out, output, 1. These form the active config.
REQ-007 SHALL have ports pending_out, output, 1: shadow differs from active; state_out, output, 2: FSM state.

Function
REQ-008 SHALL implement an FSM with states OFF=0, START=1, RUN=2. Encoding 3 is illegal and returns to OFF.
REQ-009 In OFF: gen_enable_out=0 and active config holds. enable_in=1 moves the FSM to START on the next clock.
REQ-010 In START, one cycle long: commit all inputs to active config; pulse ca_phase_load_out if ca_phase_start_in=1; clear the dwell counter; go to RUN.
REQ-011 In RUN: gen_enable_out=1.
REQ-012 In RUN: pending_out is set the cycle after any config input differs from the active value. n_sat is excluded from this comparison when scan_ena_in=1.
REQ-013 In RUN, on code_phase_done_in with pending set, or with an input difference in that same cycle: commit all differing inputs, with active values updating on the following clock edge. This gives one-cycle latency. pending_out clears.
REQ-014 A commit SHALL pulse ca_phase_load_out in the same cycle the outputs update, only if ca_phase_start_in=1 at the commit.
REQ-015 Inputs changing while no epoch occurs SHALL never reach the outputs mid-epoch.
REQ-016 Scan, when scan_ena_in=1 in RUN: an 8-bit dwell counter increments on each code_phase_done_in. At count==dwell_in the counter clears and n_sat_out advances: +1, with MAX_SAT wrapping to 1.
REQ-017 When scan_ena_in rises, scan starts from the n_sat_out active value. n_sat_out=0 scans from 1.
REQ-018 A scan advance and a pending commit on the same epoch SHALL both take effect; the scan value wins for n_sat_out.
REQ-019 A scan advance SHALL pulse ca_phase_load_out when ca_phase_start_in=1.
REQ-020 When scan_ena_in falls, n_sat_out reverts to n_sat_in at the next epoch, via the pending rule.
REQ-021 In any state, enable_in=0 SHALL go to OFF on the next clock: gen_enable_out=0, active config kept, pending cleared, dwell cleared.
REQ-022 dwell_in=0 SHALL advance n_sat_out every epoch.
REQ-023 code_phase_done_in outside RUN SHALL be ignored.

Reset
REQ-024 rst_in=1 asynchronously forces: state OFF; all outputs 0; dwell counter 0; pending 0.
REQ-025 Reset mid-commit or mid-scan SHALL leave no partial update.
REQ-026 Operation resumes on the first clock after rst_in deasserts.

Structure
REQ-027 The shared package SHALL hold: state encodings, MAX_SAT default, and a config-bundle field-width constant (5/16/8/8/1/1).
REQ-028 One sub-module SHALL be used: gps_sat_scan_ctr, covering the dwell counter, the n_sat advance, and the wrap.
REQ-029 The FSM and commit logic SHALL live in the top module.

Verification
REQ-030 Reset, then enable_in=1, n_sat_in=7, ca_phase_in=16'h0123, ca_phase_start_in=1 -> state OFF->START->RUN; outputs n_sat=7, ca_phase=0x0123; one ca_phase_load pulse.
REQ-031 In RUN, doppler_in 0x00->0x40 mid-epoch -> pending_out=1, doppler_out stays 0x00 until the cycle after code_phase_done_in, then 0x40, pending 0.
REQ-032 scan_ena_in=1, dwell_in=2, n_sat_out=31, MAX_SAT=32 -> n_sat_out 32 after 3 epochs, 1 after 6 epochs.
REQ-033 Input change and code_phase_done_in in the same cycle -> the new value commits at that epoch; no pending left.
REQ-034 enable_in=0 mid-scan, then rst_in pulse while pending -> gen_enable_out=0 next clock; after reset all outputs 0, state OFF; code_phase_done_in in OFF causes no change.

Source files
------------

// File: rtl/gps_cfg_scheduler_pkg.sv
// gps_cfg_scheduler_pkg: shared FSM encodings, scan default and config-bundle layout
//   state_e : OFF / START / RUN encodings (3 is illegal)
//   cfg_t   : active config bundle n_sat/ca_phase/doppler/snr/noise_off/signal_off
package gps_cfg_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam int MAX_SAT_DEFAULT = 32;

    localparam int N_SAT_W      = 5;
    localparam int CA_PHASE_W   = 16;
    localparam int DOPPLER_W    = 8;
    localparam int SNR_W        = 8;
    localparam int NOISE_OFF_W  = 1;
    localparam int SIGNAL_OFF_W = 1;
    localparam int CFG_W        = N_SAT_W + CA_PHASE_W + DOPPLER_W + SNR_W + NOISE_OFF_W + SIGNAL_OFF_W;
    // Everything except n_sat, which scan mode owns.
    localparam int CFG_REST_W   = CFG_W - N_SAT_W;

    typedef struct packed {
        logic [N_SAT_W-1:0]      n_sat;
        logic [CA_PHASE_W-1:0]   ca_phase;
        logic [DOPPLER_W-1:0]    doppler;
        logic [SNR_W-1:0]        snr;
        logic [NOISE_OFF_W-1:0]  noise_off;
        logic [SIGNAL_OFF_W-1:0] signal_off;
    } cfg_t;

endpackage

// File: rtl/gps_sat_scan_ctr.sv
// gps_sat_scan_ctr: dwell counter and satellite-ID advance for scan mode
//   clk_in, rst_in     : clock, async active-high reset
//   clear_in           : hold the dwell counter at 0
//   tick_in            : one epoch elapsed while scanning
//   dwell_in           : epochs per satellite minus 1
//   n_sat_in           : current active satellite ID
//   advance_out        : n_sat should take n_sat_next_out this epoch
//   n_sat_next_out     : following satellite ID, wrapping MAX_SAT to 1
module gps_sat_scan_ctr
    import gps_cfg_scheduler_pkg::*;
#(
    parameter int MAX_SAT = MAX_SAT_DEFAULT
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               clear_in,
    input  logic               tick_in,
    input  logic [7:0]         dwell_in,
    input  logic [N_SAT_W-1:0] n_sat_in,
    output logic               advance_out,
    output logic [N_SAT_W-1:0] n_sat_next_out
);

    localparam logic [N_SAT_W:0] MAX_ID = (N_SAT_W + 1)'(MAX_SAT);

    logic [7:0]       cnt_q, cnt_d;
    logic [N_SAT_W:0] sat_id;

    // A 5-bit port cannot carry ID 32, so 0 stands for 32; this also makes
    // an unconfigured 0 advance straight to 1.
    assign sat_id         = (n_sat_in == '0) ? (N_SAT_W + 1)'(32) : {1'b0, n_sat_in};
    assign n_sat_next_out = (sat_id >= MAX_ID) ? N_SAT_W'(1) : n_sat_in + N_SAT_W'(1);
    // >= keeps the dwell bounded if dwell_in is lowered below the running count.
    assign advance_out    = tick_in && !clear_in && (cnt_q >= dwell_in);

    always_comb begin
        cnt_d = clear_in ? 8'd0 : !tick_in ? cnt_q : advance_out ? 8'd0 : cnt_q + 8'd1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/gps_cfg_scheduler.sv
// gps_cfg_scheduler: moves live register-bank config into the generator only on C/A epochs
//   clk_in, rst_in                  : clock, async active-high reset
//   enable_in                       : run request; low forces OFF next clock
//   n_sat_in .. signal_off_in       : live config values
//   ca_phase_start_in               : request a phase load with each commit
//   code_phase_done_in              : 1 ms epoch pulse from the generator
//   scan_ena_in, dwell_in           : auto satellite scan, epochs per satellite minus 1
//   gen_enable_out                  : generator enable (high in RUN)
//   n_sat_out .. signal_off_out     : active config
//   ca_phase_load_out               : one-cycle pulse when the active config is loaded
//   pending_out, state_out          : shadow differs from active, FSM state
module gps_cfg_scheduler
    import gps_cfg_scheduler_pkg::*;
#(
    parameter int MAX_SAT = MAX_SAT_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic [4:0]  n_sat_in,
    input  logic        ca_phase_start_in,
    input  logic [15:0] ca_phase_in,
    input  logic [7:0]  doppler_in,
    input  logic [7:0]  snr_in,
    input  logic        noise_off_in,
    input  logic        signal_off_in,
    input  logic        code_phase_done_in,
    input  logic        scan_ena_in,
    input  logic [7:0]  dwell_in,
    output logic        gen_enable_out,
    output logic [4:0]  n_sat_out,
    output logic        ca_phase_load_out,
    output logic [15:0] ca_phase_out,
    output logic [7:0]  doppler_out,
    output logic [7:0]  snr_out,
    output logic        noise_off_out,
    output logic        signal_off_out,
    output logic        pending_out,
    output logic [1:0]  state_out
);

    state_e             state_q, state_d;
    cfg_t               cfg_q, cfg_d, cfg_in;
    logic               pending_q, pending_d;
    logic               load_q, load_d;
    logic               gen_q, gen_d;
    logic               run_act, diff, commit, advance;
    logic [N_SAT_W-1:0] n_sat_next;

    assign cfg_in  = {n_sat_in, ca_phase_in, doppler_in, snr_in, noise_off_in, signal_off_in};
    // enable_in low overrides every RUN action so the drop to OFF is clean.
    assign run_act = (state_q == ST_RUN) && enable_in;
    // n_sat belongs to the scanner while scanning, so it cannot raise pending.
    assign diff    = (!scan_ena_in && cfg_in.n_sat != cfg_q.n_sat) ||
                     (cfg_in[CFG_REST_W-1:0] != cfg_q[CFG_REST_W-1:0]);
    assign commit  = run_act && code_phase_done_in && (pending_q || diff);

    gps_sat_scan_ctr #(.MAX_SAT(MAX_SAT)) u_scan (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .clear_in       (!(run_act && scan_ena_in)),
        .tick_in        (run_act && scan_ena_in && code_phase_done_in),
        .dwell_in       (dwell_in),
        .n_sat_in       (cfg_q.n_sat),
        .advance_out    (advance),
        .n_sat_next_out (n_sat_next)
    );

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        pending_d = 1'b0;
        load_d    = 1'b0;
        if (!enable_in) state_d = ST_OFF;
        else case (state_q)
            ST_OFF:   state_d = ST_START;
            ST_START: begin
                state_d = ST_RUN;
                cfg_d   = cfg_in;
                load_d  = ca_phase_start_in;
            end
            ST_RUN:   begin
                // A commit this epoch absorbs any difference, so pending stays clear.
                pending_d = diff && !code_phase_done_in;
                if (commit) cfg_d = scan_ena_in ? {cfg_q.n_sat, cfg_in[CFG_REST_W-1:0]} : cfg_in;
                if (advance) cfg_d.n_sat = n_sat_next;
                load_d    = ca_phase_start_in && (commit || advance);
            end
            default:  state_d = ST_OFF;
        endcase
        gen_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_OFF;
            cfg_q     <= '0;
            pending_q <= 1'b0;
            load_q    <= 1'b0;
            gen_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            pending_q <= pending_d;
            load_q    <= load_d;
            gen_q     <= gen_d;
        end
    end

    assign gen_enable_out    = gen_q;
    assign n_sat_out         = cfg_q.n_sat;
    assign ca_phase_out      = cfg_q.ca_phase;
    assign doppler_out       = cfg_q.doppler;
    assign snr_out           = cfg_q.snr;
    assign noise_off_out     = cfg_q.noise_off;
    assign signal_off_out    = cfg_q.signal_off;
    assign ca_phase_load_out = load_q;
    assign pending_out       = pending_q;
    assign state_out         = state_q;

endmodule

// File: tb/tb_gps_cfg_scheduler.sv
// tb_gps_cfg_scheduler: directed self-checking bench for gps_cfg_scheduler
module tb_gps_cfg_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        enable_in, ca_phase_start_in, noise_off_in, signal_off_in;
    logic        code_phase_done_in, scan_ena_in;
    logic [4:0]  n_sat_in;
    logic [15:0] ca_phase_in;
    logic [7:0]  doppler_in, snr_in, dwell_in;
    logic        gen_enable_out, ca_phase_load_out, noise_off_out, signal_off_out, pending_out;
    logic [4:0]  n_sat_out;
    logic [15:0] ca_phase_out;
    logic [7:0]  doppler_out, snr_out;
    logic [1:0]  state_out;
    logic [38:0] cfg_out;
    logic [38:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk_in = ~clk_in;

    gps_cfg_scheduler #(.MAX_SAT(32)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .enable_in          (enable_in),
        .n_sat_in           (n_sat_in),
        .ca_phase_start_in  (ca_phase_start_in),
        .ca_phase_in        (ca_phase_in),
        .doppler_in         (doppler_in),
        .snr_in             (snr_in),
        .noise_off_in       (noise_off_in),
        .signal_off_in      (signal_off_in),
        .code_phase_done_in (code_phase_done_in),
        .scan_ena_in        (scan_ena_in),
        .dwell_in           (dwell_in),
        .gen_enable_out     (gen_enable_out),
        .n_sat_out          (n_sat_out),
        .ca_phase_load_out  (ca_phase_load_out),
        .ca_phase_out       (ca_phase_out),
        .doppler_out        (doppler_out),
        .snr_out            (snr_out),
        .noise_off_out      (noise_off_out),
        .signal_off_out     (signal_off_out),
        .pending_out        (pending_out),
        .state_out          (state_out)
    );

    assign cfg_out = {n_sat_out, ca_phase_out, doppler_out, snr_out, noise_off_out, signal_off_out};

    function automatic logic [38:0] mk(input logic [4:0] n, input logic [15:0] ca, input logic [7:0] dop,
                                       input logic [7:0] snr, input logic no, input logic so);
        return {n, ca, dop, snr, no, so};
    endfunction

    task automatic chk(input string tag, input logic [38:0] obs, input logic [38:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every commit the bench provokes pushes its expected bundle.
    task automatic check_cfg(input string tag);
        if (exp_q.size() == 0) chk({tag, "_empty"}, 39'd1, 39'd0);
        else chk(tag, cfg_out, exp_q.pop_front());
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic epoch();
        code_phase_done_in = 1'b1;
        step();
        code_phase_done_in = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1;
        enable_in = 1'b0; ca_phase_start_in = 1'b0; noise_off_in = 1'b0; signal_off_in = 1'b0;
        code_phase_done_in = 1'b0; scan_ena_in = 1'b0;
        n_sat_in = '0; ca_phase_in = '0; doppler_in = '0; snr_in = '0; dwell_in = '0;
        #12;
        chk("rst_state", 39'(state_out), 39'd0);
        chk("rst_cfg", cfg_out, 39'd0);
        chk("rst_ctrl", 39'({gen_enable_out, ca_phase_load_out, pending_out}), 39'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        enable_in = 1'b1; n_sat_in = 5'd7; ca_phase_in = 16'h0123; ca_phase_start_in = 1'b1;
        step();
        chk("start_state", 39'(state_out), 39'd1);
        chk("start_gen", 39'(gen_enable_out), 39'd0);
        step();
        chk("run_state", 39'(state_out), 39'd2);
        chk("run_gen", 39'(gen_enable_out), 39'd1);
        chk("start_load", 39'(ca_phase_load_out), 39'd1);
        exp_q.push_back(mk(5'd7, 16'h0123, 8'h00, 8'h00, 1'b0, 1'b0));
        check_cfg("start_cfg");
        step();
        chk("start_load_once", 39'(ca_phase_load_out), 39'd0);
        chk("run_no_pending", 39'(pending_out), 39'd0);

        doppler_in = 8'h40;
        step();
        chk("dop_pending", 39'(pending_out), 39'd1);
        chk("dop_held", 39'(doppler_out), 39'h00);
        step();
        chk("dop_held2", 39'(doppler_out), 39'h00);
        epoch();
        exp_q.push_back(mk(5'd7, 16'h0123, 8'h40, 8'h00, 1'b0, 1'b0));
        check_cfg("dop_commit");
        chk("dop_pending_clr", 39'(pending_out), 39'd0);
        chk("dop_load", 39'(ca_phase_load_out), 39'd1);
        step();
        chk("dop_load_once", 39'(ca_phase_load_out), 39'd0);

        snr_in = 8'h55;
        epoch();
        exp_q.push_back(mk(5'd7, 16'h0123, 8'h40, 8'h55, 1'b0, 1'b0));
        check_cfg("same_cycle_commit");
        chk("same_cycle_pending", 39'(pending_out), 39'd0);
        step();
        chk("same_cycle_pending2", 39'(pending_out), 39'd0);

        ca_phase_start_in = 1'b0;
        noise_off_in = 1'b1;
        repeat (5) step();
        chk("mid_epoch_hold", cfg_out, mk(5'd7, 16'h0123, 8'h40, 8'h55, 1'b0, 1'b0));
        chk("mid_epoch_pending", 39'(pending_out), 39'd1);
        epoch();
        exp_q.push_back(mk(5'd7, 16'h0123, 8'h40, 8'h55, 1'b1, 1'b0));
        check_cfg("noise_commit");
        chk("noload_commit", 39'(ca_phase_load_out), 39'd0);

        n_sat_in = 5'd31; ca_phase_start_in = 1'b1;
        epoch();
        exp_q.push_back(mk(5'd31, 16'h0123, 8'h40, 8'h55, 1'b1, 1'b0));
        check_cfg("nsat31_commit");
        scan_ena_in = 1'b1; dwell_in = 8'd2;
        step();
        chk("scan_no_pending", 39'(pending_out), 39'd0);
        repeat (2) begin epoch(); step(); end
        chk("scan_dwell_hold", 39'(n_sat_out), 39'd31);
        epoch();
        chk("scan_to_32", 39'(n_sat_out), 39'd0);
        chk("scan_load", 39'(ca_phase_load_out), 39'd1);
        step();
        repeat (2) begin epoch(); step(); end
        chk("scan_hold_32", 39'(n_sat_out), 39'd0);
        epoch();
        chk("scan_wrap_1", 39'(n_sat_out), 39'd1);
        dwell_in = 8'd0;
        step();
        epoch();
        chk("dwell0_advance", 39'(n_sat_out), 39'd2);

        scan_ena_in = 1'b0;
        step();
        chk("scan_off_pending", 39'(pending_out), 39'd1);
        chk("scan_off_hold", 39'(n_sat_out), 39'd2);
        epoch();
        chk("scan_off_revert", 39'(n_sat_out), 39'd31);
        chk("scan_off_pend_clr", 39'(pending_out), 39'd0);

        scan_ena_in = 1'b1; doppler_in = 8'h41;
        step();
        chk("both_pending", 39'(pending_out), 39'd1);
        epoch();
        exp_q.push_back(mk(5'd0, 16'h0123, 8'h41, 8'h55, 1'b1, 1'b0));
        check_cfg("scan_and_commit");

        doppler_in = 8'h42;
        step();
        chk("off_pre_pending", 39'(pending_out), 39'd1);
        enable_in = 1'b0;
        step();
        chk("off_gen", 39'(gen_enable_out), 39'd0);
        chk("off_state", 39'(state_out), 39'd0);
        chk("off_pending", 39'(pending_out), 39'd0);
        chk("off_cfg_kept", cfg_out, mk(5'd0, 16'h0123, 8'h41, 8'h55, 1'b1, 1'b0));
        #2 rst_in = 1'b1;
        #1;
        chk("async_rst_cfg", cfg_out, 39'd0);
        chk("async_rst_ctrl", 39'({state_out, gen_enable_out, ca_phase_load_out, pending_out}), 39'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        epoch();
        step();
        chk("off_epoch_cfg", cfg_out, 39'd0);
        chk("off_epoch_state", 39'(state_out), 39'd0);

        enable_in = 1'b1;
        step();
        chk("resume_start", 39'(state_out), 39'd1);
        step();
        chk("resume_run", 39'(state_out), 39'd2);
        exp_q.push_back(mk(5'd31, 16'h0123, 8'h42, 8'h55, 1'b1, 1'b0));
        check_cfg("resume_cfg");
        chk("resume_load", 39'(ca_phase_load_out), 39'd1);
        chk("sb_drained", 39'(exp_q.size()), 39'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
